// File: rtl/serial_link_pkg.sv
// serial_link_pkg: shared state encoding and widths for the serial shift-register link
package serial_link_pkg;
  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
  localparam int DEFAULT_WIDTH = 4;
  function automatic int BITCNT_W(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready-loaded word sent LSB-first, one bit per tick, back-to-back capable
module piso_serializer
  import serial_link_pkg::*;
#(
  parameter int n = DEFAULT_WIDTH
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic [n-1:0] din,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         tick,
  output logic         sout,
  output logic         sout_en,
  output logic         busy,
  output logic         done
);
  localparam int CW = BITCNT_W(n);
  state_t        state;
  logic [n-1:0]  shreg;
  logic [CW-1:0] cnt;
  logic          done_r;
  logic          last;
  logic          fin;
  always_comb begin
    busy       = state == ST_SHIFT;
    sout       = busy & shreg[0];
    sout_en    = busy & tick;
    done       = done_r;
    last       = cnt == CW'(n - 1);
    fin        = sout_en & last;
    load_ready = !busy | fin;
  end
  always_ff @(posedge CLK)
    if (!RSTn) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      cnt    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= fin;
      if (load_valid && load_ready) begin
        shreg <= din;
        cnt   <= '0;
        state <= ST_SHIFT;
      end else if (fin) begin
        shreg <= '0;
        state <= ST_IDLE;
      end else if (sout_en) begin
        shreg <= shreg >> 1;
        cnt   <= cnt + 1'b1;
      end
    end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in, serial-out transmitter. It is the sending end of the team's serial-in shift register link. A word is accepted through a valid/ready load handshake and shifted out LSB-first, one bit per `tick`. Its `sout`/`sout_en` pair drives the receiver's `in`/`EN` directly, so after `n` strobes the receiver's parallel output equals the loaded word.

Parameters:
- `n`, 4, word width in bits; legal values are 2 and above.

Ports:
- `CLK`  input  1  rising-edge clock.
- `RSTn`  input  1  synchronous active-low reset, sampled on the rising edge of `CLK`.
- `din`  input  `n`  parallel word to transmit.
- `load_valid`  input  1  `din` is valid.
- `load_ready`  output  1  block can accept a word this cycle.
- `tick`  input  1  bit-rate strobe; one bit is transmitted per cycle in which `tick` is high.
- `sout`  output  1  serial data, equal to the current LSB of the shift register.
- `sout_en`  output  1  receiver shift enable; high exactly on the cycles where a bit is sampled.
- `busy`  output  1  a word is in flight.
- `done`  output  1  one-cycle pulse after the last bit of a word has been sent.

Behaviour:
- State machine states: IDLE and SHIFT.
- Internal registers:
  - `shreg[n-1:0]`
  - `cnt[$clog2(n)-1:0]`, the number of bits already sent
  - `done_r`
- Reset (`RSTn` low at a rising edge of `CLK`):
  - state goes to IDLE; `shreg`, `cnt` and `done_r` clear to 0.
  - Next cycle: `load_ready`=1, `sout`=0, `sout_en`=0, `busy`=0, `done`=0.
  - Reset overrides every other input.
  - Reset mid-word abandons the word; no `done` pulse is produced.
- Output decode (combinational from registers and `tick`):
  - `sout` = `shreg[0]` in SHIFT, 0 in IDLE.
  - `sout_en` = (state==SHIFT) & `tick`.
  - `busy` = (state==SHIFT).
  - `done` = `done_r`.
  - `last` = (`cnt`==`n`-1).
  - `load_ready` = (state==IDLE) | (state==SHIFT & `tick` & `last`).
- Accept: on a rising edge with `load_valid` & `load_ready`:
  - `shreg` <= `din`, `cnt` <= 0, state <= SHIFT.
  - The first bit (`din[0]`) is visible on `sout` in the following cycle.
- SHIFT, `tick`=0: all state holds; `sout` is stable and `sout_en`=0.
- SHIFT, `tick`=1 and not `last`: `shreg` <= {1'b0, `shreg[n-1:1]`}, `cnt` <= `cnt`+1.
- SHIFT, `tick`=1 and `last` (final bit):
  - `done_r` <= 1.
  - If `load_valid` is also high: load the new word and stay in SHIFT with `cnt`=0. This is back-to-back operation with no gap bit.
  - Otherwise: state <= IDLE, `shreg` <= 0.
- `done_r` clears in every cycle that does not end a word, so `done` is exactly one cycle wide.
- Ignored inputs:
  - `tick` in IDLE has no effect and `sout_en` stays 0.
  - `load_valid` while `load_ready`=0 is ignored; the word is not captured. The source must hold `din`/`load_valid` until it sees `load_ready`.
  - `din` is sampled only on the accepting edge.
- Latency: from the accept edge, a word takes exactly `n` tick-cycles. With `tick` tied high that is `n` cycles, and `done` asserts on cycle `n`+1 after the accept edge.
- Bit ordering: the receiver samples `sout` on the same edge on which `sout_en` is high. Its right-shift with MSB insert leaves `Q`==`din` after `n` strobes.

Decomposition:
- Shared package `serial_link_pkg`:
  - state enum {`ST_IDLE`, `ST_SHIFT`}
  - `DEFAULT_WIDTH` = 4
  - a `BITCNT_W(n)` = `$clog2(n)` helper constant function
  - This package is also used by the receiver and the link top level.
- No sub-module is needed. The counter and shift register stay inline. Any tick divider lives outside this block.

Test Plan:
1. Reset: hold `RSTn`=0 for 2 cycles with `load_valid`=1 and `tick`=1 -> `load_ready`=1, `busy`=0, `sout_en`=0, `sout`=0, `done`=0 throughout. The first cycle after release accepts the word.
2. Single word, `n`=4, `din`=4'b1010, `tick`=1 constantly:
   - `sout` over the 4 `sout_en` cycles is 0,1,0,1.
   - `done` pulses 1 cycle.
   - A receiver wired to `sout`/`sout_en` reads `Q`=4'b1010.
3. Sparse tick: `din`=4'b0111, `tick` high every 3rd cycle -> exactly 4 `sout_en` pulses; `sout` holds between ticks; `busy` stays 1 for 12 or more cycles; the receiver reads 4'b0111.
4. Back-to-back: `load_valid` held high with `din`=4'hC then 4'h3, `tick`=1:
   - `load_ready` pulses on the final tick of the first word.
   - 8 consecutive `sout_en` cycles carry 0,0,1,1,1,1,0,0.
   - `done` pulses twice.
5. Busy rejection: `load_valid` with `din`=4'hF asserted mid-word while `load_ready`=0 -> the word in flight is unchanged and 4'hF is not sent unless it is held until `load_ready`.
6. Reset mid-word: `RSTn`=0 after 2 bits of 4'b1001 -> the next cycle is IDLE, `sout_en`=0, and no `done` pulse follows.
